// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant picker: owner lock, single requester, then round-robin tie-break.
// Define MEM_ARB_FIXED_PRIO_EN to always resolve contention in favour of port 0.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       rr_ptr,
  input  owner_e     owner,
  output logic [1:0] grant
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant = 2'b00;
    case (owner)
      OWN0:    grant = {1'b0, valid_0};
      OWN1:    grant = {valid_1, 1'b0};
      default: begin
        if (valid_0 && valid_1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          grant = 2'b01;
`else
          grant = rr_ptr ? 2'b10 : 2'b01;
`endif
        end else begin
          grant = {valid_1, valid_0};
        end
      end
    endcase
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = rr_ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of a single-port synchronous-read memory, with locked bursts.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic              req_we_0,
  input  logic              req_we_1,
  input  logic              req_lock_0,
  input  logic              req_lock_1,
  input  logic [ADDR_W-1:0] req_adr_0,
  input  logic [ADDR_W-1:0] req_adr_1,
  input  logic [DATA_W-1:0] req_dat_w_0,
  input  logic [DATA_W-1:0] req_dat_w_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_dat_r_0,
  output logic [DATA_W-1:0] rsp_dat_r_1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat_w,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dat_r
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

  owner_e           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             rr_ptr;
  logic             rsp_pend;
  logic             rsp_sel;
  logic [1:0]       grant;
  logic [1:0]       accept;
  logic             any_acc;
  logic             acc_lock;
  logic             stay;

  mem_arb_pick u_pick (
    .valid_0 (req_valid_0),
    .valid_1 (req_valid_1),
    .rr_ptr  (rr_ptr),
    .owner   (state),
    .grant   (grant)
  );

  // Grants are masked while reset is held so nothing reaches the memory.
  assign accept      = grant & {2{rst}};
  assign any_acc     = |accept;
  assign acc_lock    = accept[1] ? req_lock_1 : req_lock_0;
  assign stay        = any_acc && acc_lock && (burst_cnt < LAST_CNT);
  assign req_ready_0 = accept[0];
  assign req_ready_1 = accept[1];

  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_dat_w = '0;
    if (accept[1]) begin
      mem_we    = req_we_1;
      mem_adr   = req_adr_1;
      mem_dat_w = req_dat_w_1;
    end else if (accept[0]) begin
      mem_we    = req_we_0;
      mem_adr   = req_adr_0;
      mem_dat_w = req_dat_w_0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rsp_pend  <= 1'b0;
      rsp_sel   <= 1'b0;
    end else begin
      rsp_pend <= any_acc;
      if (any_acc) rsp_sel <= accept[1];
      case (state)
        IDLE: begin
          if (any_acc && acc_lock) begin
            state     <= accept[1] ? OWN1 : OWN0;
            burst_cnt <= CNT_W'(1);
          end
        end
        default: begin
          if (stay) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  // Pointer moves to the port that did not just finish its turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE) begin
      if (any_acc && !acc_lock) rr_ptr <= ~accept[1];
    end else if (!stay) begin
      rr_ptr <= (state == OWN0);
    end
  end
`endif

  assign rsp_valid_0 = rsp_pend & ~rsp_sel;
  assign rsp_valid_1 = rsp_pend & rsp_sel;
  assign rsp_dat_r_0 = rsp_valid_0 ? mem_dat_r : '0;
  assign rsp_dat_r_1 = rsp_valid_1 ? mem_dat_r : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a write-first sync-read memory model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic       req_we_0, req_we_1, req_lock_0, req_lock_1;
  logic [3:0] req_adr_0, req_adr_1, mem_adr;
  logic [7:0] req_dat_w_0, req_dat_w_1, rsp_dat_r_0, rsp_dat_r_1, mem_dat_w, mem_dat_r;
  logic       rsp_valid_0, rsp_valid_1, mem_we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_we_0(req_we_0), .req_we_1(req_we_1),
    .req_lock_0(req_lock_0), .req_lock_1(req_lock_1),
    .req_adr_0(req_adr_0), .req_adr_1(req_adr_1),
    .req_dat_w_0(req_dat_w_0), .req_dat_w_1(req_dat_w_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_dat_r_0(rsp_dat_r_0), .rsp_dat_r_1(rsp_dat_r_1),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we),
    .mem_dat_r(mem_dat_r)
  );

  // 16x8 memory: registered read address, write-first.
  logic [7:0] mem [16];
  logic [3:0] rd_adr = 4'd0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_dat_w;
    rd_adr <= mem_adr;
  end
  assign mem_dat_r = mem[rd_adr];

  typedef struct {
    string      name;
    logic       v0, v1, we0, we1, lk0, lk1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic       r0, r1, mw;
    logic [3:0] ma;
    logic [7:0] md;
    logic       rv0, rv1;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(string name,
      logic v0, logic v1, logic we0, logic we1, logic lk0, logic lk1,
      logic [3:0] a0, logic [3:0] a1, logic [7:0] d0, logic [7:0] d1,
      logic r0, logic r1, logic mw, logic [3:0] ma, logic [7:0] md,
      logic rv0, logic rv1, logic [7:0] rd0, logic [7:0] rd1);
    vec_t v;
    v.name = name; v.v0 = v0; v.v1 = v1; v.we0 = we0; v.we1 = we1;
    v.lk0 = lk0; v.lk1 = lk1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.mw = mw; v.ma = ma; v.md = md;
    v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic we0, input logic we1,
                       input logic lk0, input logic lk1, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_valid_0 = v0; req_valid_1 = v1; req_we_0 = we0; req_we_1 = we1;
    req_lock_0 = lk0; req_lock_1 = lk1; req_adr_0 = a0; req_adr_1 = a1;
    req_dat_w_0 = d0; req_dat_w_1 = d1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    //          name          v0 v1 we0 we1 lk0 lk1 a0 a1 d0 d1        r0 r1 mw ma md          rv0 rv1 rd0 rd1
    vecs[0]  = mkv("idle0",    0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mkv("p0_wr",    1, 0, 1, 0, 0, 0, 4'h3, 4'h0, 8'hA5, 8'h00, 1, 0, 1, 4'h3, 8'hA5, 0, 0, 8'h00, 8'h00);
    vecs[2]  = mkv("p0_rd",    1, 0, 0, 0, 0, 0, 4'h3, 4'h0, 8'h5A, 8'h00, 1, 0, 0, 4'h3, 8'h5A, 1, 0, 8'hA5, 8'h00);
    vecs[3]  = mkv("rd_rsp",   0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 1, 0, 8'hA5, 8'h00);
    vecs[4]  = mkv("rr_a",     1, 1, 1, 1, 0, 0, 4'h5, 4'h6, 8'h11, 8'h22, 0, 1, 1, 4'h6, 8'h22, 0, 0, 8'h00, 8'h00);
    vecs[5]  = mkv("rr_b",     1, 1, 1, 1, 0, 0, 4'h5, 4'h6, 8'h11, 8'h22, 1, 0, 1, 4'h5, 8'h11, 0, 1, 8'h00, 8'h22);
    vecs[6]  = mkv("rr_c",     1, 1, 1, 1, 0, 0, 4'h5, 4'h6, 8'h11, 8'h22, 0, 1, 1, 4'h6, 8'h22, 1, 0, 8'h11, 8'h00);
    vecs[7]  = mkv("rr_d",     1, 1, 1, 1, 0, 0, 4'h5, 4'h6, 8'h11, 8'h22, 1, 0, 1, 4'h5, 8'h11, 0, 1, 8'h00, 8'h22);
    vecs[8]  = mkv("rr_rsp",   0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 1, 0, 8'h11, 8'h00);
    vecs[9]  = mkv("lk_b1",    1, 1, 1, 1, 0, 1, 4'h1, 4'h8, 8'h44, 8'h30, 0, 1, 1, 4'h8, 8'h30, 0, 0, 8'h00, 8'h00);
    vecs[10] = mkv("lk_b2",    1, 1, 1, 1, 0, 1, 4'h1, 4'h9, 8'h44, 8'h31, 0, 1, 1, 4'h9, 8'h31, 0, 1, 8'h00, 8'h30);
    vecs[11] = mkv("lk_b3",    1, 1, 1, 1, 0, 1, 4'h1, 4'hA, 8'h44, 8'h32, 0, 1, 1, 4'hA, 8'h32, 0, 1, 8'h00, 8'h31);
    vecs[12] = mkv("lk_b4",    1, 1, 1, 1, 0, 1, 4'h1, 4'hB, 8'h44, 8'h33, 0, 1, 1, 4'hB, 8'h33, 0, 1, 8'h00, 8'h32);
    vecs[13] = mkv("lk_p0",    1, 1, 1, 1, 0, 1, 4'h1, 4'hC, 8'h44, 8'h34, 1, 0, 1, 4'h1, 8'h44, 0, 1, 8'h00, 8'h33);
    vecs[14] = mkv("lk_resume",1, 1, 1, 1, 0, 1, 4'h1, 4'hD, 8'h44, 8'h35, 0, 1, 1, 4'hD, 8'h35, 1, 0, 8'h44, 8'h00);
    vecs[15] = mkv("own1_drop",0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 0, 1, 8'h00, 8'h35);
    vecs[16] = mkv("lk0_rd",   1, 1, 0, 0, 1, 0, 4'h8, 4'h9, 8'h00, 8'h00, 1, 0, 0, 4'h8, 8'h00, 0, 0, 8'h00, 8'h00);
    vecs[17] = mkv("own0_drop",0, 1, 0, 0, 0, 0, 4'h0, 4'h9, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 1, 0, 8'h30, 8'h00);
    vecs[18] = mkv("p1_after", 0, 1, 0, 0, 0, 0, 4'h0, 4'h9, 8'h00, 8'h00, 0, 1, 0, 4'h9, 8'h00, 0, 0, 8'h00, 8'h00);
    vecs[19] = mkv("p1_rsp",   0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 0, 1, 8'h00, 8'h31);

    // Reset held with random inputs: every output must stay low.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
      #3;
      check("rst_ctl", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, mem_we}, 64'd0);
      check("rst_data", {mem_adr, mem_dat_w, rsp_dat_r_0, rsp_dat_r_1}, 64'd0);
    end
    idle_inputs();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {mem_we, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].we0, vecs[i].we1, vecs[i].lk0, vecs[i].lk1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      check({vecs[i].name, ".ready0"},  req_ready_0, vecs[i].r0);
      check({vecs[i].name, ".ready1"},  req_ready_1, vecs[i].r1);
      check({vecs[i].name, ".mem_we"},  mem_we,      vecs[i].mw);
      check({vecs[i].name, ".mem_adr"}, mem_adr,     vecs[i].ma);
      check({vecs[i].name, ".mem_dw"},  mem_dat_w,   vecs[i].md);
      check({vecs[i].name, ".rsp_v0"},  rsp_valid_0, vecs[i].rv0);
      check({vecs[i].name, ".rsp_v1"},  rsp_valid_1, vecs[i].rv1);
      check({vecs[i].name, ".rsp_d0"},  rsp_dat_r_0, vecs[i].rd0);
      check({vecs[i].name, ".rsp_d1"},  rsp_dat_r_1, vecs[i].rd1);
      @(posedge clk); #1;
    end

    // Reset mid-burst: locked read on port 1, then reset before its response.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h8, 8'h00, 8'h00);
    @(negedge clk);
    check("mid_rst.accept1", req_ready_1, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst.rsp_v1", rsp_valid_1, 1'b0);
    check("mid_rst.ready1", req_ready_1, 1'b0);
    check("mid_rst.rsp_d1", rsp_dat_r_1, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 8'h00, 8'h00);
    @(negedge clk);
    check("post_rst.ready0", req_ready_0, 1'b1);
    check("post_rst.mem_adr", mem_adr, 4'h9);
    check("post_rst.rsp_v1", rsp_valid_1, 1'b0);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    check("post_rst.rsp_v0", rsp_valid_0, 1'b1);
    check("post_rst.rsp_d0", rsp_dat_r_0, 8'h31);
    check("post_rst.rsp_v1b", rsp_valid_1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
